hilo_muldiv_unit: RTL

Iterative 32-bit multiply/divide engine in the EX stage that produces the HI/LO results for MULT, MULTU, DIV and DIVU. The results travel down the pipeline as the MEM/WB HI/LO write data, which feeds the HI/LO forwarding path and the HI/LO register file. The unit stalls the pipeline while it iterates and presents the final HI/LO pair for exactly one cycle.

---
 rtl/hilo_muldiv_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU engine producing the HI/LO pair.
// Radix-2 shift-add multiply and restoring divide. Each takes 32 CALC cycles.
// Divide by zero bypasses CALC with a fixed result.
module hilo_muldiv_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic                  flush,
    output logic                  stall_req,
    output logic                  done,
    output logic                  hilo_write_en,
    output logic [DATA_WIDTH-1:0] hi_result,
    output logic [DATA_WIDTH-1:0] lo_result
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_ab;     // product / quotient sign
    logic               neg_rem;    // remainder follows dividend sign
    logic [2*W-1:0]     acc;
    logic [2*W-1:0]     mcand;
    logic [W-1:0]       mplier;
    logic [W:0]         rem;
    logic [W-1:0]       quo;
    logic [W-1:0]       divisor;

    logic               is_signed_c;
    logic               div_by_zero_c;
    logic               accept_c;
    logic [W-1:0]       mag_a_c;
    logic [W-1:0]       mag_b_c;
    logic [2*W-1:0]     acc_nxt_c;
    logic [W+1:0]       diff_c;
    logic [W:0]         rem_nxt_c;
    logic [W-1:0]       quo_nxt_c;
    logic [2*W-1:0]     prod_fin_c;
    logic [W-1:0]       quo_fin_c;
    logic [W-1:0]       rem_fin_c;

    // Operand decode and magnitude extraction at issue
    assign is_signed_c   = ~op[0];
    assign div_by_zero_c = op[1] && (src_b == '0);
    assign accept_c      = (state == IDLE) && start && !flush;
    assign mag_a_c       = (is_signed_c && src_a[W-1]) ? -src_a : src_a;
    assign mag_b_c       = (is_signed_c && src_b[W-1]) ? -src_b : src_b;

    // Pipeline hold: combinational so the issuing instruction stalls immediately
    assign stall_req     = (accept_c && !div_by_zero_c) || (state == CALC);
    assign hilo_write_en = done;

    // One shift-add step and one restoring-divide step, plus final sign fix-up
    assign acc_nxt_c  = mplier[0] ? (acc + mcand) : acc;
    assign diff_c     = {rem, quo[W-1]} - (W+2)'(divisor);
    assign rem_nxt_c  = diff_c[W+1] ? {rem[W-1:0], quo[W-1]} : diff_c[W:0];
    assign quo_nxt_c  = {quo[W-2:0], ~diff_c[W+1]};
    assign prod_fin_c = neg_ab  ? -acc_nxt_c : acc_nxt_c;
    assign quo_fin_c  = neg_ab  ? -quo_nxt_c : quo_nxt_c;
    assign rem_fin_c  = neg_rem ? -rem_nxt_c[W-1:0] : rem_nxt_c[W-1:0];

    // Control FSM and datapath registers; flush overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            is_div    <= 1'b0;
            neg_ab    <= 1'b0;
            neg_rem   <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem       <= '0;
            quo       <= '0;
            divisor   <= '0;
            hi_result <= '0;
            lo_result <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            is_div  <= op[1];
                            neg_ab  <= is_signed_c && (src_a[W-1] ^ src_b[W-1]);
                            neg_rem <= is_signed_c && src_a[W-1];
                            cnt     <= '0;
                            acc     <= '0;
                            mcand   <= (2*W)'(mag_a_c);
                            mplier  <= mag_b_c;
                            rem     <= '0;
                            quo     <= mag_a_c;
                            divisor <= mag_b_c;
                            if (div_by_zero_c) begin
                                hi_result <= src_a;
                                lo_result <= '1;
                                done      <= 1'b1;
                                state     <= DONE;
                            end else begin
                                state <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        acc    <= acc_nxt_c;
                        mcand  <= {mcand[2*W-2:0], 1'b0};
                        mplier <= {1'b0, mplier[W-1:1]};
                        rem    <= rem_nxt_c;
                        quo    <= quo_nxt_c;
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST_ITER) begin
                            state <= DONE;
                            done  <= 1'b1;
                            if (is_div) begin
                                hi_result <= rem_fin_c;
                                lo_result <= quo_fin_c;
                            end else begin
                                hi_result <= prod_fin_c[2*W-1:W];
                                lo_result <= prod_fin_c[W-1:0];
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
